// File: rtl/ps2_scancode_rx_if.sv
// Pin-side and decoded-output signals of the PS/2 scan-code receiver.
// The slave modport is the receiver's view; the master modport is the keyboard/consumer side.
interface ps2_scancode_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       key_released;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  scan_code, scan_valid, key_released, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output scan_code, scan_valid, key_released, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and tracks
// make/break sequences so that scan_code always shows the single most recently pressed key.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input logic             clock,
  input logic             reset,
  ps2_scancode_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [12:0] TMO_LIMIT = 13'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  dat_sync_q, dat_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic        fall_q, fall_d;
  logic        dat_smp_q, dat_smp_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [12:0] tmo_q, tmo_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic [7:0]  held_q, held_d;
  logic        valid_q, valid_d;
  logic        rel_q, rel_d;
  logic        err_q, err_d;
  logic        byte_ok;

  // The fall strobe and its data sample are registered together, giving three cycles of pin-to-strobe latency.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], bus.ps2_clk};
    dat_sync_d = {dat_sync_q[0], bus.ps2_dat};
    clk_prev_d = clk_sync_q[1];
    fall_d     = clk_prev_q & ~clk_sync_q[1];
    dat_smp_d  = dat_sync_q[1];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    held_d    = held_q;
    valid_d   = 1'b0;
    rel_d     = 1'b0;
    err_d     = 1'b0;
    byte_ok   = 1'b0;

    if (state_q == IDLE || fall_q) tmo_d = '0;
    else                           tmo_d = tmo_q + 13'd1;

    case (state_q)
      IDLE: begin
        if (fall_q && !dat_smp_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {dat_smp_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = dat_smp_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (((^shift_q) ^ par_q) && dat_smp_q) byte_ok = 1'b1;
          else                                   err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the same cycle as the limit wins, so only a silent line can time out.
    if (state_q != IDLE && !fall_q && tmo_q == TMO_LIMIT) begin
      state_d = IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end

    if (err_d) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (shift_q == held_q) begin
          held_d  = 8'h00;
          valid_d = 1'b1;
          rel_d   = 1'b1;
        end
      end else if (shift_q != held_q) begin
        held_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
      fall_q     <= 1'b0;
      dat_smp_q  <= 1'b0;
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      held_q     <= 8'h00;
      valid_q    <= 1'b0;
      rel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      dat_smp_q  <= dat_smp_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      held_q     <= held_d;
      valid_q    <= valid_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
    end
  end

  // Frame payload is only consumed after a full frame, so it needs no reset.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign bus.scan_code    = held_q;
  assign bus.scan_valid   = valid_q;
  assign bus.key_released = rel_q;
  assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: a table of frames with fixed expectations, hand-written timeout
// and mid-frame reset sequences, then random frames checked against a key-state model.
module tb_ps2_scancode_rx;

  localparam int HALF = 20;

  logic clk;
  logic rst_n;
  ps2_scancode_rx_if bus ();

  ps2_scancode_rx dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters and protocol-violation counter maintained on the falling edge.
  int         n_v = 0, n_r = 0, n_e = 0, viol = 0;
  logic       pv, pr, pe;
  logic [7:0] last_code;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv        <= 1'b0;
      pr        <= 1'b0;
      pe        <= 1'b0;
      last_code <= 8'h00;
    end else begin
      n_v  <= n_v + int'(bus.scan_valid);
      n_r  <= n_r + int'(bus.key_released);
      n_e  <= n_e + int'(bus.frame_err);
      viol <= viol + int'(bus.scan_valid && pv) + int'(bus.key_released && pr)
                   + int'(bus.frame_err && pe) + int'(bus.key_released && !bus.scan_valid)
                   + int'(bus.scan_code != last_code && !bus.scan_valid);
      pv        <= bus.scan_valid;
      pr        <= bus.key_released;
      pe        <= bus.frame_err;
      last_code <= bus.scan_code;
    end
  end

  // Reference key state, advanced per received frame.
  logic [7:0] m_held;
  bit         m_brk, m_ext;

  task automatic model_apply(input logic [7:0] d, input bit bad, output int ev, output int er,
                             output int ee);
    ev = 0; er = 0; ee = 0;
    if (bad) begin
      ee = 1; m_brk = 0; m_ext = 0;
    end else if (d == 8'hF0) m_brk = 1;
    else if (d == 8'hE0) m_ext = 1;
    else if (m_ext) begin
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      m_brk = 0;
      if (d == m_held) begin
        m_held = 8'h00; ev = 1; er = 1;
      end
    end else if (d != m_held) begin
      m_held = d; ev = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_dat = bits[i];
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_dat = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input bit bad_par,
                             input bit bad_stop, input logic [7:0] exp_code, input int exp_v,
                             input int exp_r, input int exp_e);
    int bv, br, be;
    bv = n_v; br = n_r; be = n_e;
    send_bits(d, bad_par, bad_stop, 11);
    wait_cyc(20);
    check({tag, " code"}, int'(bus.scan_code), int'(exp_code));
    check({tag, " valid_pulses"}, n_v - bv, exp_v);
    check({tag, " release_pulses"}, n_r - br, exp_r);
    check({tag, " err_pulses"}, n_e - be, exp_e);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_code;
    int         exp_v;
    int         exp_r;
    int         exp_e;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int ev, er, ee, bv, be;
    logic [7:0] pool[8];
    logic [7:0] d;
    bit bp, bs;

    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1, 0, 0};
    tbl[1]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 0, 0, 0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 0, 0, 0};
    tbl[3]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 0, 0, 0};
    tbl[4]  = '{8'h1C, 1'b0, 1'b0, 8'h00, 1, 1, 0};
    tbl[5]  = '{8'h1C, 1'b1, 1'b0, 8'h00, 0, 0, 1};
    tbl[6]  = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1, 0, 0};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 8'h1B, 0, 0, 0};
    tbl[8]  = '{8'h74, 1'b0, 1'b0, 8'h1B, 0, 0, 0};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 8'h1B, 0, 0, 0};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 8'h1B, 0, 0, 0};
    tbl[11] = '{8'h74, 1'b0, 1'b0, 8'h1B, 0, 0, 0};
    tbl[12] = '{8'h22, 1'b0, 1'b0, 8'h22, 1, 0, 0};
    tbl[13] = '{8'hF0, 1'b0, 1'b0, 8'h22, 0, 0, 0};
    tbl[14] = '{8'h1B, 1'b0, 1'b0, 8'h22, 0, 0, 0};
    tbl[15] = '{8'hF0, 1'b0, 1'b0, 8'h22, 0, 0, 0};
    tbl[16] = '{8'h2B, 1'b0, 1'b1, 8'h22, 0, 0, 1};
    tbl[17] = '{8'h22, 1'b0, 1'b0, 8'h22, 0, 0, 0};
    tbl[18] = '{8'hF0, 1'b0, 1'b0, 8'h22, 0, 0, 0};
    tbl[19] = '{8'h22, 1'b0, 1'b0, 8'h00, 1, 1, 0};

    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hF0, 8'hE0, 8'h74};

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    rst_n = 1'b0;
    m_held = 8'h00; m_brk = 0; m_ext = 0;
    wait_cyc(5);
    check("reset code", int'(bus.scan_code), 0);
    check("reset valid", int'(bus.scan_valid), 0);
    check("reset released", int'(bus.key_released), 0);
    check("reset err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    wait_cyc(10);

    for (int i = 0; i < 20; i++) begin
      model_apply(tbl[i].d, tbl[i].bad_par | tbl[i].bad_stop, ev, er, ee);
      frame_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].bad_par, tbl[i].bad_stop,
                  tbl[i].exp_code, tbl[i].exp_v, tbl[i].exp_r, tbl[i].exp_e);
    end

    // Abandoned frame: five bits, then a silent line past the timeout.
    bv = n_v; be = n_e;
    send_bits(8'h1C, 1'b0, 1'b0, 5);
    wait_cyc(5100);
    check("timeout err_pulses", n_e - be, 1);
    check("timeout valid_pulses", n_v - bv, 0);
    check("timeout code", int'(bus.scan_code), 0);
    model_apply(8'h00, 1'b1, ev, er, ee);
    model_apply(8'h23, 1'b0, ev, er, ee);
    frame_check("after_timeout", 8'h23, 1'b0, 1'b0, 8'h23, 1, 0, 0);

    // Reset arriving in the middle of a frame.
    send_bits(8'h1C, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midreset code", int'(bus.scan_code), 0);
    check("midreset valid", int'(bus.scan_valid), 0);
    check("midreset released", int'(bus.key_released), 0);
    check("midreset err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    m_held = 8'h00; m_brk = 0; m_ext = 0;
    wait_cyc(10);
    model_apply(8'h2B, 1'b0, ev, er, ee);
    frame_check("after_reset", 8'h2B, 1'b0, 1'b0, 8'h2B, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) d = 8'($urandom_range(1, 255));
      else                           d = pool[$urandom_range(0, 7)];
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 15) == 0);
      model_apply(d, bp | bs, ev, er, ee);
      frame_check($sformatf("rnd%0d_%02h", i, d), d, bp, bs, m_held, ev, er, ee);
    end

    check("pulse_width_and_stability_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
